// File: rtl/ysyx_24100029_wbu.sv
// ysyx_24100029_wbu: write-back stage.
// Registers one result from the LSU, then drives the GPR write port, the
// CSR write port and the retire record for exactly one cycle.
// Optional feature macro: YSYX_24100029_PERF_CNT_EN adds the 64-bit mcycle and
// minstret counters behind perf_sel_i / perf_rdata_o. When the macro is not
// defined, perf_rdata_o is tied to zero.
module ysyx_24100029_wbu (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_last_i,
  output logic        ready_last_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        R_wen_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] Ex_result_i,
  input  logic [31:0] LSU_Rdata_i,
  input  logic        mem_ren_i,
  input  logic [3:0]  csr_wen_i,
  input  logic [31:0] csrs_i,
  output logic        rf_wen_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [3:0]  csr_we_o,
  output logic [31:0] csr_wdata_o,
  output logic        commit_valid_o,
  output logic [31:0] commit_pc_o,
  output logic [31:0] commit_inst_o,
  input  logic [1:0]  perf_sel_i,
  output logic [31:0] perf_rdata_o
);

  logic        ready_q,     ready_d;
  logic        wb_valid_q,  wb_valid_d;
  logic [31:0] pc_q,        pc_d;
  logic [31:0] inst_q,      inst_d;
  logic        r_wen_q,     r_wen_d;
  logic [4:0]  rd_q,        rd_d;
  logic [31:0] ex_result_q, ex_result_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;
  logic        mem_ren_q,   mem_ren_d;
  logic [3:0]  csr_wen_q,   csr_wen_d;
  logic [31:0] csrs_q,      csrs_d;
  logic        fire;

  assign fire = valid_last_i & ready_q;

  // Next-state: holding registers load only on a handshake, otherwise hold.
  always_comb begin
    ready_d     = 1'b1;
    wb_valid_d  = fire;
    pc_d        = pc_q;
    inst_d      = inst_q;
    r_wen_d     = r_wen_q;
    rd_d        = rd_q;
    ex_result_d = ex_result_q;
    lsu_rdata_d = lsu_rdata_q;
    mem_ren_d   = mem_ren_q;
    csr_wen_d   = csr_wen_q;
    csrs_d      = csrs_q;
    if (fire) begin
      pc_d        = pc_i;
      inst_d      = inst_i;
      r_wen_d     = R_wen_i;
      rd_d        = rd_i;
      ex_result_d = Ex_result_i;
      lsu_rdata_d = LSU_Rdata_i;
      mem_ren_d   = mem_ren_i;
      csr_wen_d   = csr_wen_i;
      csrs_d      = csrs_i;
    end
  end

  // Stage registers with synchronous reset; reset drops any pending result.
  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      pc_q        <= '0;
      inst_q      <= '0;
      r_wen_q     <= 1'b0;
      rd_q        <= '0;
      ex_result_q <= '0;
      lsu_rdata_q <= '0;
      mem_ren_q   <= 1'b0;
      csr_wen_q   <= '0;
      csrs_q      <= '0;
    end else begin
      ready_q     <= ready_d;
      wb_valid_q  <= wb_valid_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      r_wen_q     <= r_wen_d;
      rd_q        <= rd_d;
      ex_result_q <= ex_result_d;
      lsu_rdata_q <= lsu_rdata_d;
      mem_ren_q   <= mem_ren_d;
      csr_wen_q   <= csr_wen_d;
      csrs_q      <= csrs_d;
    end
  end

  // Output strobes are gated by wb_valid; x0 is never written.
  always_comb begin
    ready_last_o   = ready_q;
    rf_wen_o       = wb_valid_q & r_wen_q & (rd_q != 5'd0);
    rf_waddr_o     = rd_q;
    rf_wdata_o     = mem_ren_q ? lsu_rdata_q : ex_result_q;
    csr_we_o       = wb_valid_q ? csr_wen_q : 4'b0000;
    csr_wdata_o    = csrs_q;
    commit_valid_o = wb_valid_q;
    commit_pc_o    = pc_q;
    commit_inst_o  = inst_q;
  end

`ifdef YSYX_24100029_PERF_CNT_EN
  logic [63:0] mcycle_q,   mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  // Counter next-state: both wrap naturally at all-ones.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q;
    if (wb_valid_q) minstret_d = minstret_q + 64'd1;
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // Counter read mux.
  always_comb begin
    perf_rdata_o = 32'd0;
    case (perf_sel_i)
      2'd0: perf_rdata_o = mcycle_q[31:0];
      2'd1: perf_rdata_o = mcycle_q[63:32];
      2'd2: perf_rdata_o = minstret_q[31:0];
      2'd3: perf_rdata_o = minstret_q[63:32];
      default: perf_rdata_o = 32'd0;
    endcase
  end
`else
  logic unused_perf_sel;
  assign unused_perf_sel = ^perf_sel_i;
  assign perf_rdata_o    = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_24100029_wbu.sv
// Directed bench for ysyx_24100029_wbu: reset behaviour, a vector table of
// single transfers, back-to-back commits, mid-operation reset and, when
// YSYX_24100029_PERF_CNT_EN is defined, the performance counters.
module tb_ysyx_24100029_wbu;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_last;
  logic        ready_last;
  logic [31:0] pc, inst;
  logic        r_wen;
  logic [4:0]  rd;
  logic [31:0] ex_result, lsu_rdata;
  logic        mem_ren;
  logic [3:0]  csr_wen;
  logic [31:0] csrs;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  csr_we;
  logic [31:0] csr_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc, commit_inst;
  logic [1:0]  perf_sel;
  logic [31:0] perf_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ysyx_24100029_wbu dut (
    .clock          (clock),
    .reset          (reset),
    .valid_last_i   (valid_last),
    .ready_last_o   (ready_last),
    .pc_i           (pc),
    .inst_i         (inst),
    .R_wen_i        (r_wen),
    .rd_i           (rd),
    .Ex_result_i    (ex_result),
    .LSU_Rdata_i    (lsu_rdata),
    .mem_ren_i      (mem_ren),
    .csr_wen_i      (csr_wen),
    .csrs_i         (csrs),
    .rf_wen_o       (rf_wen),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .csr_we_o       (csr_we),
    .csr_wdata_o    (csr_wdata),
    .commit_valid_o (commit_valid),
    .commit_pc_o    (commit_pc),
    .commit_inst_o  (commit_inst),
    .perf_sel_i     (perf_sel),
    .perf_rdata_o   (perf_rdata)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rwen;
    logic [4:0]  rd;
    logic [31:0] ex;
    logic [31:0] lsu;
    logic        memren;
    logic [3:0]  csrwen;
    logic [31:0] csrs;
    logic        e_rf_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_csr_we;
    logic [31:0] e_csr_wdata;
    logic        e_commit;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] in,
                       input logic rw, input logic [4:0] r, input logic [31:0] ex,
                       input logic [31:0] ld, input logic mr, input logic [3:0] cw,
                       input logic [31:0] cs);
    valid_last = v;  pc = p;  inst = in;  r_wen = rw;  rd = r;
    ex_result = ex;  lsu_rdata = ld;  mem_ren = mr;  csr_wen = cw;  csrs = cs;
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".rf_wen"}, rf_wen, 0);
    chk({name, ".csr_we"}, csr_we, 0);
    chk({name, ".commit"}, commit_valid, 0);
  endtask

  initial begin
    reset    = 1'b1;
    perf_sel = 2'd0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            v  pc            inst          rw rd  ex            lsu           mr csrwen   csrs          rfw wa  wdata         csrwe    csrwdata      cv pc
    vecs[0] = '{1, 32'h80000000, 32'h00002283, 1, 5,  32'h80000010, 32'hDEADBEEF, 1, 4'b0000, 32'h00000000, 1, 5,  32'hDEADBEEF, 4'b0000, 32'h00000000, 1, 32'h80000000};
    vecs[1] = '{0, 32'h11111111, 32'h22222222, 1, 9,  32'h00000055, 32'h00000066, 0, 4'b1111, 32'h77777777, 0, 5,  32'hDEADBEEF, 4'b0000, 32'h00000000, 0, 32'h80000000};
    vecs[2] = '{1, 32'h80000004, 32'h00000013, 1, 0,  32'h00001234, 32'h0000FFFF, 0, 4'b0000, 32'h00000000, 0, 0,  32'h00001234, 4'b0000, 32'h00000000, 1, 32'h80000004};
    vecs[3] = '{1, 32'h80000008, 32'h34101073, 0, 0,  32'h00000000, 32'h00000000, 0, 4'b0100, 32'h80000004, 0, 0,  32'h00000000, 4'b0100, 32'h80000004, 1, 32'h80000008};
    vecs[4] = '{0, 32'h33333333, 32'h44444444, 1, 7,  32'h00000099, 32'h00000088, 1, 4'b0010, 32'h12345678, 0, 0,  32'h00000000, 4'b0000, 32'h80000004, 0, 32'h80000008};
    vecs[5] = '{1, 32'h8000000C, 32'h30001073, 1, 31, 32'hCAFE0000, 32'h0BADF00D, 0, 4'b1001, 32'h00001800, 1, 31, 32'hCAFE0000, 4'b1001, 32'h00001800, 1, 32'h8000000C};
    vecs[6] = '{1, 32'h80000010, 32'h00000000, 0, 3,  32'h00000077, 32'h00000011, 0, 4'b0000, 32'h00000000, 0, 3,  32'h00000077, 4'b0000, 32'h00000000, 1, 32'h80000010};
    vecs[7] = '{1, 32'h80000014, 32'h0000A083, 1, 1,  32'hFFFFFFFF, 32'h00000000, 1, 4'b0000, 32'h00000000, 1, 1,  32'h00000000, 4'b0000, 32'h00000000, 1, 32'h80000014};

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst.ready", ready_last, 0);
      chk_idle("rst");
    end
    reset = 1'b0;
    chk("rel.ready_before_edge1", ready_last, 0);

    // A transfer offered on the first edge after release must be dropped.
    drive(1, 32'h00000BAD, 32'h0, 1, 7, 32'h1, 32'h2, 0, 4'b0001, 32'h3);
    step();
    chk("rel.ready_after_edge1", ready_last, 1);
    chk_idle("rel.drop");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("rel.ready_after_edge2", ready_last, 1);
    chk_idle("rel.hold");

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].inst, vecs[i].rwen, vecs[i].rd,
            vecs[i].ex, vecs[i].lsu, vecs[i].memren, vecs[i].csrwen, vecs[i].csrs);
      step();
      chk($sformatf("vec%0d.rf_wen", i),    rf_wen,       vecs[i].e_rf_wen);
      chk($sformatf("vec%0d.waddr", i),     rf_waddr,     vecs[i].e_waddr);
      chk($sformatf("vec%0d.wdata", i),     rf_wdata,     vecs[i].e_wdata);
      chk($sformatf("vec%0d.csr_we", i),    csr_we,       vecs[i].e_csr_we);
      chk($sformatf("vec%0d.csr_wdata", i), csr_wdata,    vecs[i].e_csr_wdata);
      chk($sformatf("vec%0d.commit", i),    commit_valid, vecs[i].e_commit);
      chk($sformatf("vec%0d.pc", i),        commit_pc,    vecs[i].e_pc);
      if (vecs[i].v)
        chk($sformatf("vec%0d.inst", i), commit_inst, vecs[i].inst);
    end

    // Single-cycle strobe: with the source idle, everything drops next edge.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk_idle("after_vec");
    chk("after_vec.pc_hold", commit_pc, 32'h80000014);

    // Reset arriving with a transfer: nothing is committed for it.
    drive(1, 32'h00000444, 32'h0, 1, 4, 32'h44, 32'h0, 0, 4'b1000, 32'h5);
    reset = 1'b1;
    step();
    chk_idle("midrst");
    chk("midrst.ready", ready_last, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    step();
    chk_idle("midrst.after");
    chk("midrst.pc_cleared", commit_pc, 0);

    // Four back-to-back transfers.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h00000100 + 32'(4 * i), 32'h00000013, 1, 5'(10 + i),
            32'(i + 1), 32'h0, 0, 4'b0000, 32'h0);
      step();
      chk($sformatf("b2b%0d.commit", i), commit_valid, 1);
      chk($sformatf("b2b%0d.pc", i),     commit_pc, 32'h00000100 + 32'(4 * i));
      chk($sformatf("b2b%0d.wdata", i),  rf_wdata, 32'(i + 1));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk_idle("b2b.end");

`ifdef YSYX_24100029_PERF_CNT_EN
    perf_sel = 2'd2;
    #1;
    chk("perf.minstret_lo", perf_rdata, 4);
    perf_sel = 2'd3;
    #1;
    chk("perf.minstret_hi", perf_rdata, 0);
    force dut.mcycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
    release dut.mcycle_q;
    perf_sel = 2'd1;
    #1;
    chk("perf.mcycle_preload_hi", perf_rdata, 32'hFFFFFFFF);
    step();
    perf_sel = 2'd0;
    #1;
    chk("perf.mcycle_wrap_lo", perf_rdata, 0);
    perf_sel = 2'd1;
    #1;
    chk("perf.mcycle_wrap_hi", perf_rdata, 0);
`else
    for (int s = 0; s < 4; s++) begin
      perf_sel = 2'(s);
      #1;
      chk($sformatf("perf.tied_sel%0d", s), perf_rdata, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_24100029_wbu.md
YSYX_24100029_WBU -- requirements
Module: ysyx_24100029_wbu

Interface
REQ-001 clock  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  synchronous, active-high.
REQ-003 valid_last  in  1  upstream (LSU) result valid.
REQ-004 ready_last  out  1  WBU can accept a result.
REQ-005 pc, inst  in  32 each  PC and instruction of the incoming result.
REQ-006 R_wen  in  1; rd  in  5  GPR write enable and destination.
REQ-007 Ex_result, LSU_Rdata  in  32 each  ALU result and load data.
REQ-008 mem_ren  in  1  result is a load.
REQ-009 csr_wen  in  4; csrs  in  32  one-hot CSR write select and write data.
REQ-010 rf_wen  out  1; rf_waddr  out  5; rf_wdata  out  32  GPR write port.
REQ-011 csr_we  out  4; csr_wdata  out  32  CSR write port: bit0 mstatus, bit1 mtvec, bit2 mepc, bit3 mcause.
REQ-012 commit_valid  out  1; commit_pc, commit_inst  out  32 each  retire record.
REQ-013 perf_sel  in  2; perf_rdata  out  32  counter read port (YSYX_24100029_PERF_CNT_EN only).

Function
REQ-014 Handshake: transfer when valid_last & ready_last are both high at a rising edge; all inputs are captured into holding registers on that edge only.
REQ-015 ready_last: registered; 0 during reset; 1 from the first edge after reset deassertion; stays 1 (single-cycle stage, no back-pressure).
REQ-016 wb_valid: registered; set on a transfer; cleared on the next edge unless another transfer occurs; back-to-back transfers keep it high.
REQ-017 Latency: exactly 1 cycle from the transfer edge to the write-port and commit outputs.
REQ-018 rf_wen = wb_valid & R_wen_reg & (rd_reg != 0); a write to x0 is never issued.
REQ-019 rf_waddr = rd_reg; rf_wdata = mem_ren_reg ? LSU_Rdata_reg : Ex_result_reg.
REQ-020 csr_we = wb_valid ? csr_wen_reg : 4'b0000; csr_wdata = csrs_reg; a non-one-hot csr_wen is passed through unchanged.
REQ-021 commit_valid = wb_valid; commit_pc = pc_reg; commit_inst = inst_reg.
REQ-022 Data held steady while wb_valid is low; no output strobe fires without a transfer.
REQ-023 A transfer on the first edge after reset deassertion is not accepted, because ready_last is still 0.

Reset
REQ-024 While reset is high, on each edge: ready_last=0, wb_valid=0, all holding registers=0, counters=0; rf_wen, csr_we and commit_valid are therefore 0.
REQ-025 Reset mid-operation discards any pending result; no write or commit is issued for it.

Configuration
REQ-026 With macro YSYX_24100029_PERF_CNT_EN defined:
- 64-bit mcycle increments every non-reset cycle.
- 64-bit minstret increments on every cycle with commit_valid=1.
- Both counters wrap to 0 after all-ones.
- perf_rdata is selected by perf_sel: 0 mcycle[31:0], 1 mcycle[63:32], 2 minstret[31:0], 3 minstret[63:32].
REQ-027 Without the macro: no counters; perf_sel is ignored; perf_rdata is tied to 0.

Verification
REQ-028 Reset 3 cycles, then release -> ready_last=0 on the first edge after release and 1 on the second; all strobes 0 throughout.
REQ-029 Load transfer: mem_ren=1, R_wen=1, rd=5, LSU_Rdata=0xDEADBEEF, Ex_result=0x80000010 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, commit_valid=1 for one cycle.
REQ-030 ALU transfer with R_wen=1, rd=0, Ex_result=0x1234 -> rf_wen=0, commit_valid=1.
REQ-031 csr_wen=4'b0100, csrs=0x80000004 -> csr_we=4'b0100 and csr_wdata=0x80000004 for exactly one cycle.
REQ-032 Four back-to-back transfers with valid_last held high -> commit_valid high for 4 consecutive cycles with PCs in order; with PERF_CNT_EN, minstret=4.
REQ-033 PERF_CNT_EN: preload mcycle to 0xFFFFFFFF_FFFFFFFF via hierarchical force, run one cycle -> perf_sel=0 and perf_sel=1 both read 0.
